// File: rtl/wave_scope_renderer.sv
// Audio scope: captures a decimated, optionally triggered sample stream into a
// double-buffered frame memory and renders it onto the VGA pixel stream.
module wave_scope_renderer #(
  parameter int SAMPLE_W = 10,
  parameter int H_RES    = 1280,
  parameter int V_RES    = 1024,
  parameter int COLOR_W  = 12,
  parameter int DECIM_W  = 4
) (
  input  logic                CLK_VGA,
  input  logic                RESET_N,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] wave_sample,
  input  logic [1:0]          mode,
  input  logic                freeze,
  input  logic                trig_en,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [DECIM_W-1:0]  decim,
  input  logic [COLOR_W-1:0]  wave_color,
  input  logic [11:0]         VGA_HORZ_COORD,
  input  logic [11:0]         VGA_VERT_COORD,
  output logic [COLOR_W-1:0]  VGA_Pixel,
  output logic                capture_done,
  output logic [1:0]          cap_state
);

  // state   | meaning
  // ARMED   | waiting for the free-run start sample or a rising trigger crossing
  // CAPTURE | filling the write bank, one accepted sample per column
  // HOLD    | frame frozen after a swap; strobes ignored until freeze drops

  localparam int COL_W = $clog2(H_RES);
  localparam int IDX_W = $clog2(2 * H_RES);

  typedef enum logic [1:0] {
    ARMED   = 2'b00,
    CAPTURE = 2'b01,
    HOLD    = 2'b10
  } state_t;

  state_t              state;
  logic                disp_bank;
  logic                frame_valid;
  logic                prev_valid;
  logic [SAMPLE_W-1:0] prev_acc;
  logic [COL_W-1:0]    wr_addr;
  logic [DECIM_W-1:0]  dcnt;
  logic [DECIM_W-1:0]  decim_q;

  logic [SAMPLE_W-1:0] mem [0:2*H_RES-1];
  logic [SAMPLE_W-1:0] rd_data;

  logic [DECIM_W-1:0]  decim_eff;
  logic                accepted;
  logic                trig_hit;
  logic                start;
  logic                wr_en;
  logic                last_wr;
  logic [COL_W-1:0]    wr_col;
  logic [COL_W-1:0]    rd_col;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;

  assign decim_eff = (state == ARMED) ? decim : decim_q;
  assign accepted  = sample_valid && (state != HOLD) && (dcnt == '0);
  assign trig_hit  = !trig_en ||
                     (prev_valid && (prev_acc < trig_level) && (wave_sample >= trig_level));
  assign start     = (state == ARMED) && accepted && trig_hit;
  assign wr_col    = (state == CAPTURE) ? wr_addr + COL_W'(1) : '0;
  assign wr_en     = start || ((state == CAPTURE) && accepted);
  assign last_wr   = (state == CAPTURE) && accepted && (wr_col == COL_W'(H_RES - 1));

  // Writes always target the bank that is not being displayed.
  assign wr_idx = IDX_W'(wr_col) + (disp_bank ? IDX_W'(0) : IDX_W'(H_RES));
  assign rd_col = (VGA_HORZ_COORD < 12'(H_RES)) ? COL_W'(VGA_HORZ_COORD) : '0;
  assign rd_idx = IDX_W'(rd_col) + (disp_bank ? IDX_W'(H_RES) : IDX_W'(0));

  always_ff @(posedge CLK_VGA) begin
    if (wr_en) mem[wr_idx] <= wave_sample;
    rd_data <= mem[rd_idx];
  end

  always_ff @(posedge CLK_VGA or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= ARMED;
      disp_bank    <= 1'b0;
      frame_valid  <= 1'b0;
      prev_valid   <= 1'b0;
      prev_acc     <= '0;
      wr_addr      <= '0;
      dcnt         <= '0;
      decim_q      <= '0;
      capture_done <= 1'b0;
    end else begin
      capture_done <= 1'b0;
      if (sample_valid && (state != HOLD))
        dcnt <= (dcnt >= decim_eff) ? '0 : dcnt + DECIM_W'(1);
      if (accepted) begin
        prev_acc   <= wave_sample;
        prev_valid <= 1'b1;
      end
      case (state)
        ARMED: begin
          decim_q <= decim;
          if (start) begin
            wr_addr <= '0;
            state   <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (accepted) begin
            wr_addr <= wr_col;
            if (last_wr) begin
              wr_addr      <= '0;
              disp_bank    <= ~disp_bank;
              capture_done <= 1'b1;
              frame_valid  <= 1'b1;
              state        <= freeze ? HOLD : ARMED;
            end
          end
        end
        HOLD: begin
          if (!freeze) state <= ARMED;
        end
        default: state <= ARMED;
      endcase
    end
  end

  assign cap_state = state;

  logic [11:0] h_q, v_q, y, y_p, y_prev, mid;
  logic [1:0]  mode_q;
  logic        lit;

  assign y   = 12'(V_RES - 1) - 12'(rd_data);
  assign mid = 12'(V_RES / 2);
  assign y_p = (h_q == 12'd0) ? y : y_prev;

  always_comb begin
    lit = 1'b0;
    if ((h_q < 12'(H_RES)) && frame_valid) begin
      case (mode_q)
        2'b01:   lit = (y < mid) ? (v_q >= y && v_q <= mid) : (v_q >= mid && v_q <= y);
        2'b10:   lit = (v_q == y);
        2'b11:   lit = (y < y_p) ? (v_q >= y && v_q <= y_p) : (v_q >= y_p && v_q <= y);
        default: lit = 1'b0;
      endcase
    end
  end

  // Mode travels with its coordinates so a change applies from the next pixel.
  always_ff @(posedge CLK_VGA or negedge RESET_N) begin
    if (!RESET_N) begin
      h_q       <= '0;
      v_q       <= '0;
      mode_q    <= 2'b00;
      y_prev    <= '0;
      VGA_Pixel <= '0;
    end else begin
      h_q       <= VGA_HORZ_COORD;
      v_q       <= VGA_VERT_COORD;
      mode_q    <= mode;
      y_prev    <= y;
      VGA_Pixel <= lit ? wave_color : '0;
    end
  end

endmodule

// File: tb/tb_wave_scope_renderer.sv
// Bench for wave_scope_renderer: frame captures driven from loops, pixels checked
// through a latency-aware scoreboard plus a table of fixed render vectors.
module tb_wave_scope_renderer;
  localparam int SW = 10;
  localparam int HR = 1280;
  localparam int VR = 1024;
  localparam int CW = 12;
  localparam int DW = 4;
  localparam logic [CW-1:0] COL = 12'hA5C;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sample_valid;
  logic [SW-1:0] wave_sample;
  logic [1:0]    mode;
  logic          freeze;
  logic          trig_en;
  logic [SW-1:0] trig_level;
  logic [DW-1:0] decim;
  logic [CW-1:0] wave_color;
  logic [11:0]   hcoord;
  logic [11:0]   vcoord;
  logic [CW-1:0] pixel;
  logic          capture_done;
  logic [1:0]    cap_state;

  always #5 clk = ~clk;

  wave_scope_renderer #(
    .SAMPLE_W(SW), .H_RES(HR), .V_RES(VR), .COLOR_W(CW), .DECIM_W(DW)
  ) dut (
    .CLK_VGA(clk), .RESET_N(rst_n), .sample_valid(sample_valid), .wave_sample(wave_sample),
    .mode(mode), .freeze(freeze), .trig_en(trig_en), .trig_level(trig_level),
    .decim(decim), .wave_color(wave_color), .VGA_HORZ_COORD(hcoord),
    .VGA_VERT_COORD(vcoord), .VGA_Pixel(pixel), .capture_done(capture_done),
    .cap_state(cap_state)
  );

  typedef struct {
    int            due;
    logic [CW-1:0] exp;
    string         nm;
  } sb_t;

  typedef struct {
    logic [1:0]    m;
    int            h;
    int            v;
    logic [CW-1:0] exp;
    string         nm;
  } vec_t;

  sb_t  sbq[$];
  sb_t  e;
  vec_t vecs[18];
  int   n_tests = 0;
  int   n_fail = 0;
  int   ncyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   n0;
  int   model[0:HR-1];
  bit   model_valid = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Pixel expectations fall due two clocks after their coordinates were driven.
  always @(negedge clk) begin
    ncyc++;
    if (capture_done === 1'b1) begin
      done_cnt++;
      done_cyc = ncyc;
    end
    while (sbq.size() > 0 && sbq[0].due <= ncyc) begin
      e = sbq.pop_front();
      check(e.nm, 32'(pixel), 32'(e.exp));
    end
  end

  function automatic logic [CW-1:0] exp_pix(logic [1:0] m, int h, int v);
    int y, yp, lo, hi;
    bit lit;
    if (!model_valid || h >= HR || m == 2'b00) return '0;
    y  = VR - 1 - model[h];
    yp = (h == 0) ? y : VR - 1 - model[h-1];
    case (m)
      2'b01: begin
        lo = (y < VR/2) ? y : VR/2;
        hi = (y < VR/2) ? VR/2 : y;
        lit = (v >= lo) && (v <= hi);
      end
      2'b10: lit = (v == y);
      default: begin
        lo = (y < yp) ? y : yp;
        hi = (y < yp) ? yp : y;
        lit = (v >= lo) && (v <= hi);
      end
    endcase
    return lit ? COL : '0;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sample_valid = 1'b0;
    end
  endtask

  task automatic strobe(int val);
    tick();
    sample_valid = 1'b1;
    wave_sample  = val[SW-1:0];
  endtask

  task automatic drive_pix(logic [1:0] m, int h, int v);
    tick();
    sample_valid = 1'b0;
    mode   = m;
    hcoord = h[11:0];
    vcoord = v[11:0];
  endtask

  task automatic expect_pix(string nm, logic [CW-1:0] ex);
    sbq.push_back('{ncyc + 2, ex, nm});
  endtask

  task automatic pix(logic [1:0] m, int h, int v, string nm);
    drive_pix(m, h, v);
    expect_pix(nm, exp_pix(m, h, v));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b01, 0, 511, '0, "fill_c0_511"};
    vecs[1]  = '{2'b01, 0, 512, COL, "fill_c0_512"};
    vecs[2]  = '{2'b01, 0, 1023, COL, "fill_c0_1023"};
    vecs[3]  = '{2'b01, 1, 0, COL, "fill_c1_0"};
    vecs[4]  = '{2'b01, 1, 512, COL, "fill_c1_512"};
    vecs[5]  = '{2'b01, 1, 513, '0, "fill_c1_513"};
    vecs[6]  = '{2'b11, 1, 0, COL, "line_c1_0"};
    vecs[7]  = '{2'b11, 1, 700, COL, "line_c1_700"};
    vecs[8]  = '{2'b11, 1, 1023, COL, "line_c1_1023"};
    vecs[9]  = '{2'b10, 0, 1023, COL, "dot_c0_1023"};
    vecs[10] = '{2'b10, 0, 1022, '0, "dot_c0_1022"};
    vecs[11] = '{2'b10, 1, 0, COL, "dot_c1_0"};
    vecs[12] = '{2'b00, 0, 1023, '0, "off_c0_1023"};
    vecs[13] = '{2'b00, 1, 300, '0, "off_c1_300"};
    vecs[14] = '{2'b10, 1280, 1023, '0, "dot_h1280"};
    vecs[15] = '{2'b01, 1500, 800, '0, "fill_h1500"};
    vecs[16] = '{2'b11, 0, 1023, COL, "line_c0_1023"};
    vecs[17] = '{2'b11, 0, 1022, '0, "line_c0_1022"};

    rst_n = 1'b0; sample_valid = 1'b0; wave_sample = '0; mode = 2'b00; freeze = 1'b0;
    trig_en = 1'b0; trig_level = '0; decim = '0; wave_color = COL; hcoord = '0; vcoord = '0;
    idle(3);
    check("rst_pixel", 32'(pixel), 0);
    check("rst_done", 32'(capture_done), 0);
    check("rst_state", 32'(cap_state), 0);
    rst_n = 1'b1;
    idle(2);
    for (int r = 1016; r <= 1020; r++) pix(2'b10, 5, r, "blank_before_frame");
    idle(3);

    // free-running ramp
    done_cnt = 0;
    for (int i = 0; i < HR; i++) begin
      strobe(i % 1024);
      if (i == 0) n0 = ncyc;
    end
    idle(4);
    check("ramp_done_cnt", 32'(done_cnt), 1);
    check("ramp_done_lat", 32'(done_cyc - n0), 1280);
    check("ramp_state", 32'(cap_state), 0);
    for (int c = 0; c < HR; c++) model[c] = c % 1024;
    model_valid = 1'b1;
    for (int r = 1016; r <= 1020; r++) pix(2'b10, 5, r, "ramp_dot_c5");
    drive_pix(2'b10, 5, 1018);
    expect_pix("ramp_dot_c5_1018", COL);
    idle(3);

    // frame with s=0 at column 0 and s=1023 at column 1, then fixed vectors
    done_cnt = 0;
    for (int i = 0; i < HR; i++) strobe(i == 0 ? 0 : (i == 1 ? 1023 : (i * 7) % 1024));
    idle(4);
    check("render_done_cnt", 32'(done_cnt), 1);
    model[0] = 0;
    model[1] = 1023;
    for (int c = 2; c < HR; c++) model[c] = (c * 7) % 1024;
    for (int k = 0; k < 18; k++) begin
      if (vecs[k].h > 0 && vecs[k].h < HR) drive_pix(vecs[k].m, vecs[k].h - 1, vecs[k].v);
      drive_pix(vecs[k].m, vecs[k].h, vecs[k].v);
      expect_pix(vecs[k].nm, vecs[k].exp);
    end
    for (int c = 0; c < 4; c++) pix(2'b11, c, 600, "line_sweep");
    idle(3);

    // trigger on a rising crossing of 512
    rst_n = 1'b0;
    model_valid = 1'b0;
    idle(1);
    rst_n = 1'b1;
    trig_en = 1'b1;
    trig_level = 10'd512;
    idle(1);
    done_cnt = 0;
    for (int k = 0; k < HR + 2; k++) strobe((500 + 10 * k) % 1024);
    idle(4);
    check("trig_done_cnt", 32'(done_cnt), 1);
    check("trig_state", 32'(cap_state), 0);
    for (int c = 0; c < HR; c++) model[c] = (500 + 10 * (c + 2)) % 1024;
    model_valid = 1'b1;
    drive_pix(2'b10, 0, 1023 - 520);
    expect_pix("trig_addr0_is_520", COL);
    drive_pix(2'b10, 0, 1023 - 510);
    expect_pix("trig_510_not_stored", '0);
    for (int c = 1; c < 4; c++) pix(2'b10, c, 1023 - model[c], "trig_dot");
    idle(3);

    // decimation by 4
    trig_en = 1'b0;
    decim = 4'd3;
    idle(2);
    done_cnt = 0;
    for (int i = 0; i < 5120; i++) begin
      strobe((i * 37 + 11) % 1024);
      if (i == 0) n0 = ncyc;
    end
    idle(4);
    check("decim_done_cnt", 32'(done_cnt), 1);
    check("decim_done_lat", 32'(done_cyc - n0), 5117);
    check("decim_state", 32'(cap_state), 0);
    for (int c = 0; c < HR; c++) model[c] = (4 * c * 37 + 11) % 1024;
    foreach (vecs[k]) begin
      int c;
      c = (k * 71) % HR;
      pix(2'b10, c, 1023 - model[c], "decim_kept");
      pix(2'b10, c, 1023 - ((4 * c + 1) * 37 + 11) % 1024, "decim_skipped");
    end
    idle(3);
    decim = '0;
    idle(2);

    // freeze raised mid-capture
    done_cnt = 0;
    for (int i = 0; i < HR; i++) begin
      if (i == 600) freeze = 1'b1;
      strobe((i * 13 + 100) % 1024);
      if (i == 700) check("frz_still_capturing", 32'(cap_state), 1);
    end
    idle(3);
    check("frz_done_cnt", 32'(done_cnt), 1);
    check("frz_hold_state", 32'(cap_state), 2);
    for (int c = 0; c < HR; c++) model[c] = (c * 13 + 100) % 1024;
    for (int i = 0; i < 60; i++) strobe((i * 3) % 1024);
    idle(2);
    check("frz_hold_after_strobes", 32'(done_cnt), 1);
    check("frz_hold_state2", 32'(cap_state), 2);
    for (int c = 10; c < 14; c++) pix(2'b10, c, 1023 - model[c], "frz_display");
    idle(3);
    tick();
    freeze = 1'b0;
    tick();
    check("frz_release_state", 32'(cap_state), 0);
    idle(2);

    // reset in the middle of a capture
    drive_pix(2'b10, 20, 1023 - model[20]);
    expect_pix("pre_rst_lit", COL);
    idle(3);
    for (int i = 0; i <= 700; i++) strobe((i * 5 + 300) % 1024);
    check("pre_rst_pixel", 32'(pixel), 32'(COL));
    rst_n = 1'b0;
    model_valid = 1'b0;
    #1;
    check("rst_async_pixel", 32'(pixel), 0);
    idle(2);
    rst_n = 1'b1;
    for (int c = 20; c < 24; c++) pix(2'b10, c, 1023 - model[c], "post_rst_blank");
    idle(3);
    drive_pix(2'b10, 20, 1023 - model[20]);
    done_cnt = 0;
    for (int i = 0; i < HR; i++) begin
      strobe((i * 11 + 7) % 1024);
      if (i == 640 || i == HR - 1) check("blank_until_done", 32'(pixel), 0);
    end
    idle(4);
    check("rst_new_done_cnt", 32'(done_cnt), 1);
    for (int c = 0; c < HR; c++) model[c] = (c * 11 + 7) % 1024;
    model_valid = 1'b1;
    for (int c = 20; c < 24; c++) pix(2'b10, c, 1023 - model[c], "post_frame_lit");
    for (int c = 20; c < 24; c++) pix(2'b01, c, 300, "post_frame_fill");
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
